// File: rtl/fsm_frame_sched.sv
// Round-robin scheduler that time-shares one bit-serial Mealy encoder between two
// word-level requesters, clearing the encoder before each frame and reassembling its output.
module fsm_frame_sched #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         req0_valid,
    input  logic [W-1:0] req0_data,
    output logic         req0_ready,
    input  logic         req1_valid,
    input  logic [W-1:0] req1_data,
    output logic         req1_ready,
    output logic         fsm_x,
    output logic         fsm_reset,
    input  logic         fsm_y,
    output logic         out_valid,
    output logic [W-1:0] out_data,
    output logic         out_id,
    input  logic         out_ready
);

    localparam int CW = $clog2(W) + 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(W - 1);

    typedef enum logic [1:0] {
        IDLE,
        CLR,
        SHIFT,
        DONE
    } state_t;

    state_t        state;
    logic [W-1:0]  in_shreg;
    logic [W-1:0]  out_shreg;
    logic [CW-1:0] count;
    logic          last;
    logic          id;
    logic          grant0;
    logic          grant1;

    // On contention the requester that was not served last wins.
    always_comb begin
        grant0 = req0_valid && (!req1_valid || last);
        grant1 = req1_valid && (!req0_valid || !last);
    end

    assign req0_ready = reset && (state == IDLE) && grant0;
    assign req1_ready = reset && (state == IDLE) && grant1;
    assign fsm_x      = (state == SHIFT) ? in_shreg[0] : 1'b0;
    assign fsm_reset  = !reset || (state == CLR);
    assign out_valid  = (state == DONE);
    assign out_data   = out_shreg;
    assign out_id     = id;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            in_shreg  <= '0;
            out_shreg <= '0;
            count     <= '0;
            last      <= 1'b1;
            id        <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant0 || grant1) begin
                        in_shreg <= grant1 ? req1_data : req0_data;
                        id       <= grant1;
                        state    <= CLR;
                    end
                end
                CLR: begin
                    count     <= '0;
                    out_shreg <= '0;
                    state     <= SHIFT;
                end
                SHIFT: begin
                    // OR-in via shift keeps the index width independent of the counter width.
                    out_shreg <= out_shreg | ({{(W-1){1'b0}}, fsm_y} << count);
                    in_shreg  <= in_shreg >> 1;
                    if (count == LAST_BIT) begin
                        state <= DONE;
                    end else begin
                        count <= count + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        last  <= id;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fsm_frame_sched.sv
// Directed bench for fsm_frame_sched with a behavioural Mealy encoder that remembers
// history, so a skipped encoder clear shows up in the results.
module tb_fsm_frame_sched;

    logic       clk = 1'b0;
    logic       reset;
    logic       req0_valid, req1_valid;
    logic [7:0] req0_data, req1_data;
    logic       req0_ready, req1_ready;
    logic       fsm_x, fsm_reset, fsm_y;
    logic       out_valid, out_id, out_ready;
    logic [7:0] out_data;
    logic [1:0] enc_st;

    int total = 0;
    int bad   = 0;

    fsm_frame_sched #(.W(8)) dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
        .fsm_x(fsm_x), .fsm_reset(fsm_reset), .fsm_y(fsm_y),
        .out_valid(out_valid), .out_data(out_data), .out_id(out_id), .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    // Encoder: A --1/1--> B; B --0/1--> C, B --1/0--> D; C --x/~x--> D; D sinks with y=0.
    // So 8'h01 -> 8'h07, 8'hFF -> 8'h01, 8'h02 -> 8'h0E, 8'h05 -> 8'h03.
    always @(posedge clk) begin
        if (fsm_reset) enc_st <= 2'd0;
        else begin
            case (enc_st)
                2'd0:    enc_st <= fsm_x ? 2'd1 : 2'd0;
                2'd1:    enc_st <= fsm_x ? 2'd3 : 2'd2;
                default: enc_st <= 2'd3;
            endcase
        end
    end

    always_comb begin
        fsm_y = 1'b0;
        case (enc_st)
            2'd0:    fsm_y = fsm_x;
            2'd1:    fsm_y = !fsm_x;
            2'd2:    fsm_y = !fsm_x;
            default: fsm_y = 1'b0;
        endcase
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Presents a request, waits for its accept and result; lat counts edges after the accept edge.
    task automatic run_frame(input logic v0, input logic [7:0] d0, input logic v1,
                             input logic [7:0] d1, input bit keep, output logic acc1,
                             output logic [7:0] res, output logic res_id, output int lat,
                             output bit tmo);
        bit got;
        tmo = 0; acc1 = 0; res = '0; res_id = 0; lat = -1; got = 0;
        req0_valid = v0; req0_data = d0; req1_valid = v1; req1_data = d1; out_ready = 1;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (req0_ready || req1_ready) begin
                acc1 = req1_ready;
                got = 1;
            end
            tick();
        end
        if (!got) tmo = 1;
        if (!keep) begin
            req0_valid = 0;
            req1_valid = 0;
        end
        got = 0;
        for (int i = 0; i < 30 && !tmo && !got; i++) begin
            @(negedge clk);
            if (out_valid) begin
                res = out_data; res_id = out_id; lat = i; got = 1;
            end
            tick();
        end
        if (!got) tmo = 1;
    endtask

    task automatic test_reset;
        reset = 0; req0_valid = 1; req1_valid = 0; req0_data = 8'h01; req1_data = 8'h00;
        out_ready = 1;
        #12;
        total++; if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_out_valid got=%b want=0", out_valid); end
        total++; if (req0_ready !== 1'b0) begin bad++; $display("[TB] FAIL reset_ready got=%b want=0", req0_ready); end
        total++; if (fsm_reset !== 1'b1) begin bad++; $display("[TB] FAIL reset_fsm_reset got=%b want=1", fsm_reset); end
        total++; if (fsm_x !== 1'b0) begin bad++; $display("[TB] FAIL reset_fsm_x got=%b want=0", fsm_x); end
        total++; if (out_id !== 1'b0) begin bad++; $display("[TB] FAIL reset_out_id got=%b want=0", out_id); end
        total++; if (out_data !== 8'h00) begin bad++; $display("[TB] FAIL reset_out_data got=%h want=00", out_data); end
        req0_valid = 0;
        tick();
        reset = 1;
        tick();
        total++; if (fsm_reset !== 1'b0) begin bad++; $display("[TB] FAIL idle_fsm_reset got=%b want=0", fsm_reset); end
    endtask

    task automatic test_single_frame;
        logic a; logic [7:0] r; logic rid; int lat; bit tmo;
        run_frame(1, 8'h01, 0, 8'h00, 0, a, r, rid, lat, tmo);
        total++; if (tmo !== 1'b0) begin bad++; $display("[TB] FAIL single_timeout got=%b want=0", tmo); end
        total++; if (a !== 1'b0) begin bad++; $display("[TB] FAIL single_accept got=%b want=0", a); end
        total++; if (r !== 8'h07) begin bad++; $display("[TB] FAIL single_data got=%h want=07", r); end
        total++; if (rid !== 1'b0) begin bad++; $display("[TB] FAIL single_id got=%b want=0", rid); end
        total++; if (lat != 9) begin bad++; $display("[TB] FAIL single_latency got=%0d want=9", lat); end
    endtask

    task automatic test_data_values;
        logic a; logic [7:0] r; logic rid; int lat; bit tmo;
        logic       vsel [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        logic [7:0] din  [4] = '{8'hFF, 8'h00, 8'h02, 8'h05};
        logic [7:0] dexp [4] = '{8'h01, 8'h00, 8'h0E, 8'h03};
        for (int k = 0; k < 4; k++) begin
            run_frame(!vsel[k], din[k], vsel[k], din[k], 0, a, r, rid, lat, tmo);
            total++; if (tmo !== 1'b0) begin bad++; $display("[TB] FAIL data_timeout[%0d] got=%b want=0", k, tmo); end
            total++; if (r !== dexp[k]) begin bad++; $display("[TB] FAIL data_value[%0d] got=%h want=%h", k, r, dexp[k]); end
            total++; if (rid !== vsel[k]) begin bad++; $display("[TB] FAIL data_id[%0d] got=%b want=%b", k, rid, vsel[k]); end
        end
    endtask

    task automatic test_contention;
        logic a; logic [7:0] r; logic rid; int lat; bit tmo;
        logic [7:0] rexp;
        reset = 0;
        tick();
        reset = 1;
        for (int k = 0; k < 4; k++) begin
            run_frame(1, 8'h01, 1, 8'hFF, 1, a, r, rid, lat, tmo);
            rexp = (k % 2 == 0) ? 8'h07 : 8'h01;
            total++; if (a !== 1'(k % 2)) begin bad++; $display("[TB] FAIL contention_grant[%0d] got=%b want=%0d", k, a, k % 2); end
            total++; if (r !== rexp) begin bad++; $display("[TB] FAIL contention_data[%0d] got=%h want=%h", k, r, rexp); end
            total++; if (lat != 9) begin bad++; $display("[TB] FAIL contention_latency[%0d] got=%0d want=9", k, lat); end
        end
        req0_valid = 0;
        req1_valid = 0;
    endtask

    task automatic test_backpressure;
        logic a; logic [7:0] r; logic rid; int lat; bit tmo; bit got;
        req0_valid = 1; req0_data = 8'h05; out_ready = 0; got = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (req0_ready) got = 1;
            tick();
        end
        req0_valid = 0; req1_valid = 1; req1_data = 8'h02;
        got = 0;
        for (int i = 0; i < 30 && !got; i++) begin
            @(negedge clk);
            if (out_valid) got = 1;
            else tick();
        end
        total++; if (got !== 1'b1) begin bad++; $display("[TB] FAIL stall_reach_done got=%b want=1", got); end
        for (int i = 0; i < 5; i++) begin
            total++; if (out_valid !== 1'b1 || out_data !== 8'h03 || out_id !== 1'b0)
                begin bad++; $display("[TB] FAIL stall_hold[%0d] got=%b/%h/%b want=1/03/0", i, out_valid, out_data, out_id); end
            total++; if (req1_ready !== 1'b0) begin bad++; $display("[TB] FAIL stall_ready[%0d] got=%b want=0", i, req1_ready); end
            @(negedge clk);
        end
        out_ready = 1;
        tick();
        total++; if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL release_valid got=%b want=0", out_valid); end
        total++; if (req1_ready !== 1'b1) begin bad++; $display("[TB] FAIL release_ready got=%b want=1", req1_ready); end
        run_frame(0, 8'h00, 1, 8'h02, 0, a, r, rid, lat, tmo);
        total++; if (r !== 8'h0E || rid !== 1'b1 || tmo !== 1'b0)
            begin bad++; $display("[TB] FAIL after_stall got=%h/%b want=0E/1", r, rid); end
    endtask

    task automatic test_back_to_back;
        logic a; logic [7:0] r; logic rid; int lat; bit tmo;
        run_frame(1, 8'hFF, 0, 8'h00, 0, a, r, rid, lat, tmo);
        total++; if (r !== 8'h01) begin bad++; $display("[TB] FAIL isolate_first got=%h want=01", r); end
        run_frame(1, 8'h01, 0, 8'h00, 0, a, r, rid, lat, tmo);
        total++; if (r !== 8'h07) begin bad++; $display("[TB] FAIL isolate_second got=%h want=07", r); end
    endtask

    task automatic test_reset_mid_frame;
        logic a; logic [7:0] r; logic rid; int lat; bit tmo; bit got; bit seen;
        req1_valid = 1; req1_data = 8'h01; out_ready = 1; got = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (req1_ready) got = 1;
            tick();
        end
        req1_valid = 0;
        repeat (4) tick();
        reset = 0;
        #1;
        total++; if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL abort_valid got=%b want=0", out_valid); end
        total++; if (fsm_reset !== 1'b1) begin bad++; $display("[TB] FAIL abort_fsm_reset got=%b want=1", fsm_reset); end
        total++; if (fsm_x !== 1'b0) begin bad++; $display("[TB] FAIL abort_fsm_x got=%b want=0", fsm_x); end
        total++; if (out_id !== 1'b0) begin bad++; $display("[TB] FAIL abort_out_id got=%b want=0", out_id); end
        total++; if (out_data !== 8'h00) begin bad++; $display("[TB] FAIL abort_out_data got=%h want=00", out_data); end
        repeat (2) tick();
        reset = 1;
        seen = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (out_valid) seen = 1;
        end
        total++; if (seen !== 1'b0) begin bad++; $display("[TB] FAIL abort_no_result got=%b want=0", seen); end
        tick();
        run_frame(1, 8'h01, 0, 8'h00, 0, a, r, rid, lat, tmo);
        total++; if (r !== 8'h07 || rid !== 1'b0 || tmo !== 1'b0)
            begin bad++; $display("[TB] FAIL abort_recover got=%h/%b want=07/0", r, rid); end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_data_values();
        test_contention();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_frame();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
